pmod_dac_spi_driver: RTL
========================

PMOD_DAC_SPI_DRIVER -- requirements
Module: pmod_dac_spi_driver

Interface
REQ-001 Parameter RESOLUTION, default 16, sample width and SPI bits per frame.
REQ-002 Parameter SCLK_HALF, default 4, clk cycles per dac_sclk half-period (legal range 1 or more).
REQ-003 Parameter LDAC_LEN, default 2, clk cycles dac_ldac_n is held low per update.
REQ-004 Parameter CS_GAP, default 2, minimum clk cycles with dac_cs_n high between frames.
REQ-005 Port clk  in  1  single system clock; all logic SHALL be on its rising edge.
REQ-006 Port rst  in  1  reset, asynchronous and active-high.
REQ-007 Port sample_data  in  RESOLUTION  sample to convert, unsigned.
REQ-008 Port sample_valid  in  1  upstream asserts when sample_data is valid.
REQ-009 Port sample_ready  out  1  driver can accept a sample this cycle.
REQ-010 Port dac_cs_n  out  1  SPI chip select, active-low.
REQ-011 Port dac_ldac_n  out  1  DAC load strobe, active-low.
REQ-012 Port dac_din  out  1  SPI data, MSB first.
REQ-013 Port dac_sclk  out  1  SPI clock, mode 0 (idle low, DAC samples on rising edge).
REQ-014 Port busy  out  1  high whenever the state is not IDLE.
REQ-015 Port update_count  out  16  count of completed LDAC strobes, wraps from 0xFFFF to 0x0000.

Function
REQ-016 All outputs SHALL be registered; no output SHALL depend combinationally on any input.
REQ-017 Handshake: a sample transfers on a clk edge where sample_valid=1 and sample_ready=1; sample_data SHALL be captured on that edge.
REQ-018 Buffering: one-entry pending register; sample_ready=1 exactly when that register is empty.
REQ-019 Acceptance while a frame is in progress SHALL fill the pending register and SHALL NOT disturb the current frame.
REQ-020 FSM states SHALL be IDLE, SETUP, SHIFT, LOAD and GAP.
REQ-021 IDLE: all strobes inactive; when the pending register is full, move the sample to the shift register, free the pending register, and enter SETUP on the next edge.
REQ-022 SETUP: dac_cs_n=0, dac_sclk=0, dac_din=shift-register MSB, held for SCLK_HALF cycles, then enter SHIFT.
REQ-023 SHIFT: exactly RESOLUTION dac_sclk pulses, each SCLK_HALF cycles high then SCLK_HALF cycles low.
REQ-024 In SHIFT, dac_din SHALL update (shift left) only on a sclk falling transition, so din is stable for the full high phase.
REQ-025 After the low phase of the last pulse, dac_cs_n SHALL rise, dac_sclk SHALL stay 0, and the FSM SHALL enter LOAD.
REQ-026 LOAD: dac_cs_n=1, dac_ldac_n=0 for exactly LDAC_LEN cycles; update_count SHALL increment by 1 on the final LOAD cycle; then enter GAP.
REQ-027 GAP: all strobes inactive for CS_GAP cycles; then enter SETUP directly if the pending register is full, otherwise IDLE.
REQ-028 dac_cs_n and dac_ldac_n SHALL never be low in the same cycle.
REQ-029 Timing: handshake edge to dac_cs_n low = 2 cycles when IDLE with pending empty.
REQ-030 Frame period (cs_n fall to next cs_n fall, back-to-back) = SCLK_HALF*(2*RESOLUTION+1)+LDAC_LEN+CS_GAP; 136 cycles at defaults.
REQ-031 Internal counters SHALL be sized for the maximum parameter values, with no overflow inside a frame.
REQ-032 Simultaneous pending-register free (IDLE/GAP to SETUP) and new acceptance on the same edge SHALL keep the new sample in pending; no loss, no duplicate.

Reset
REQ-033 Reset values: dac_cs_n=1, dac_ldac_n=1, dac_sclk=0, dac_din=0, busy=0, update_count=0, sample_ready=0, state=IDLE, pending register empty.
REQ-034 sample_ready SHALL go to 1 on the first clk edge after rst deasserts.
REQ-035 rst asserted mid-frame SHALL immediately force the REQ-033 values; the partial frame and any pending sample are discarded, and no LDAC pulse occurs.

Verification
REQ-036 Single sample 0xA5C3 at defaults -> din bits sampled on the 16 sclk rising edges read 1010_0101_1100_0011; cs_n low for 132 cycles; ldac_n low 2 cycles; update_count=1.
REQ-037 Three samples with valid held continuously -> sample_ready drops after 2 accepts and recovers; frames are back-to-back with 136-cycle period; update_count=3; data order preserved.
REQ-038 Samples 0x0000 and 0xFFFF -> din constant 0 or 1 across each frame; cs_n/ldac_n overlap never observed.
REQ-039 rst pulse during the 8th sclk pulse -> outputs reach reset values asynchronously; no ldac_n low; the next sample is sent complete and correct.
REQ-040 Preload update_count=0xFFFF via 65535 frames (or a force) and send one more frame -> update_count=0x0000.
REQ-041 SCLK_HALF=1, RESOLUTION=12, sample 0x800 -> 12 pulses, cs_n low for 25 cycles, din high only for the first bit.

Source files
------------

// File: rtl/pmod_dac_spi_driver.sv
// SPI driver for a Pmod DAC: one-entry sample buffer, mode-0 serial frame, then an LDAC strobe.
// Every output is a flop; strobes follow the FSM state with a one-cycle registered lag.
module pmod_dac_spi_driver #(
    parameter int unsigned RESOLUTION = 16,
    parameter int unsigned SCLK_HALF  = 4,
    parameter int unsigned LDAC_LEN   = 2,
    parameter int unsigned CS_GAP     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [RESOLUTION-1:0] sample_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  dac_cs_n,
    output logic                  dac_ldac_n,
    output logic                  dac_din,
    output logic                  dac_sclk,
    output logic                  busy,
    output logic [15:0]           update_count
);

    // Zero-length LOAD/GAP phases are not meaningful; clamp them to one cycle.
    localparam int unsigned LdacCyc = (LDAC_LEN == 0) ? 1 : LDAC_LEN;
    localparam int unsigned GapCyc  = (CS_GAP == 0) ? 1 : CS_GAP;
    localparam int unsigned Span01  = (2 * SCLK_HALF > LdacCyc) ? 2 * SCLK_HALF : LdacCyc;
    localparam int unsigned MaxCnt  = (Span01 > GapCyc) ? Span01 : GapCyc;
    localparam int unsigned CntW    = $clog2(MaxCnt + 1);
    localparam int unsigned BitW    = $clog2(RESOLUTION + 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StLoad, StGap} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [BitW-1:0]         bit_q, bit_d;
    logic [RESOLUTION-1:0]   shreg_q, shreg_d;
    logic [RESOLUTION-1:0]   pend_data_q, pend_data_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [15:0]             update_count_q, update_count_d;
    logic                    ready_q, ready_d;
    logic                    cs_n_q, cs_n_d;
    logic                    ldac_n_q, ldac_n_d;
    logic                    sclk_q, sclk_d;
    logic                    din_q, din_d;
    logic                    busy_q, busy_d;
    logic                    accept;
    logic                    take;
    logic                    in_frame;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        shreg_d        = shreg_q;
        pend_data_d    = pend_data_q;
        pend_vld_d     = pend_vld_q;
        update_count_d = update_count_q;
        take           = 1'b0;
        accept         = sample_valid & ready_q;

        unique case (state_q)
            StIdle: begin
                if (pend_vld_q) begin
                    shreg_d = pend_data_q;
                    take    = 1'b1;
                    cnt_d   = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (cnt_q == CntW'(SCLK_HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShift: begin
                // Shift at the end of the high phase so din moves together with the sclk fall.
                if (cnt_q == CntW'(SCLK_HALF - 1)) begin
                    shreg_d = {shreg_q[RESOLUTION-2:0], 1'b0};
                end
                if (cnt_q == CntW'(2 * SCLK_HALF - 1)) begin
                    cnt_d = '0;
                    if (bit_q == BitW'(RESOLUTION - 1)) begin
                        state_d = StLoad;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLoad: begin
                if (cnt_q == CntW'(LdacCyc - 1)) begin
                    cnt_d          = '0;
                    update_count_d = update_count_q + 16'd1;
                    state_d        = StGap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GapCyc - 1)) begin
                    cnt_d = '0;
                    if (pend_vld_q) begin
                        shreg_d = pend_data_q;
                        take    = 1'b1;
                        state_d = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A same-edge accept wins over the free, so the new sample stays pending.
        if (take) begin
            pend_vld_d = 1'b0;
        end
        if (accept) begin
            pend_vld_d  = 1'b1;
            pend_data_d = sample_data;
        end
        ready_d = ~pend_vld_d;

        in_frame = (state_q == StSetup) || (state_q == StShift);
        cs_n_d   = ~in_frame;
        ldac_n_d = (state_q != StLoad);
        sclk_d   = (state_q == StShift) && (cnt_q < CntW'(SCLK_HALF));
        din_d    = in_frame & shreg_q[RESOLUTION-1];
        busy_d   = (state_q != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            bit_q          <= '0;
            shreg_q        <= '0;
            pend_data_q    <= '0;
            pend_vld_q     <= 1'b0;
            update_count_q <= '0;
            ready_q        <= 1'b0;
            cs_n_q         <= 1'b1;
            ldac_n_q       <= 1'b1;
            sclk_q         <= 1'b0;
            din_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            shreg_q        <= shreg_d;
            pend_data_q    <= pend_data_d;
            pend_vld_q     <= pend_vld_d;
            update_count_q <= update_count_d;
            ready_q        <= ready_d;
            cs_n_q         <= cs_n_d;
            ldac_n_q       <= ldac_n_d;
            sclk_q         <= sclk_d;
            din_q          <= din_d;
            busy_q         <= busy_d;
        end
    end

    assign sample_ready = ready_q;
    assign dac_cs_n     = cs_n_q;
    assign dac_ldac_n   = ldac_n_q;
    assign dac_sclk     = sclk_q;
    assign dac_din      = din_q;
    assign busy         = busy_q;
    assign update_count = update_count_q;

endmodule
